// File: rtl/ysyx_23060332_lsu_pkg.sv
// ysyx_23060332_lsu_pkg: op encoding, bus widths and FSM states shared by the LSU
package ysyx_23060332_lsu_pkg;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int LSU_OP_W   = 4;

    localparam int OP_STORE = 3;
    localparam int OP_UNS   = 2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [LSU_OP_W-1:0] OP_LB  = 4'b0000;
    localparam logic [LSU_OP_W-1:0] OP_LH  = 4'b0001;
    localparam logic [LSU_OP_W-1:0] OP_LW  = 4'b0010;
    localparam logic [LSU_OP_W-1:0] OP_LBU = 4'b0100;
    localparam logic [LSU_OP_W-1:0] OP_LHU = 4'b0101;
    localparam logic [LSU_OP_W-1:0] OP_SB  = 4'b1000;
    localparam logic [LSU_OP_W-1:0] OP_SH  = 4'b1001;
    localparam logic [LSU_OP_W-1:0] OP_SW  = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} lsu_state_e;
endpackage

// File: rtl/ysyx_23060332_lsu_align.sv
// ysyx_23060332_lsu_align: fault detection, store lane placement and load extraction
module ysyx_23060332_lsu_align
    import ysyx_23060332_lsu_pkg::*;
(
    input  logic [LSU_OP_W-1:0]   op,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [MEM_DATA_W-1:0] wdata,
    input  logic [MEM_DATA_W-1:0] rdata,
    output logic                  fault,
    output logic [3:0]            wmask,
    output logic [MEM_DATA_W-1:0] wdata_sh,
    output logic [MEM_DATA_W-1:0] rdata_ext
);
    logic [1:0]            size;
    logic [MEM_DATA_W-1:0] rd_sh;

    // reserved encodings are folded into the fault so they never reach memory
    always_comb begin
        size      = op[1:0];
        fault     = (size == SZ_H && addr[0]) || (size == SZ_W && addr[1:0] != 2'b00) ||
                    size == 2'b11 || (op[OP_STORE] && op[OP_UNS]);
        wmask     = size == SZ_B ? 4'b0001 << addr[1:0] :
                    size == SZ_H ? 4'b0011 << addr[1:0] : 4'b1111;
        wdata_sh  = wdata << {addr[1:0], 3'b000};
        rd_sh     = rdata >> {addr[1:0], 3'b000};
        rdata_ext = size == SZ_B ? {{24{~op[OP_UNS] & rd_sh[7]}}, rd_sh[7:0]} :
                    size == SZ_H ? {{16{~op[OP_UNS] & rd_sh[15]}}, rd_sh[15:0]} : rd_sh;
    end
endmodule

// File: rtl/ysyx_23060332_lsu.sv
// ysyx_23060332_lsu: single-outstanding load/store unit driving the data-memory request channel
module ysyx_23060332_lsu
    import ysyx_23060332_lsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LSU_OP_W-1:0]   in_op,
    input  logic [MEM_ADDR_W-1:0] in_addr,
    input  logic [MEM_DATA_W-1:0] in_wdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_wen,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    output logic [7:0]            mem_wmask,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [MEM_DATA_W-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MEM_DATA_W-1:0] out_rdata,
    output logic                  out_fault
);
    lsu_state_e            state_q, state_d;
    logic [LSU_OP_W-1:0]   op_q, cur_op;
    logic [MEM_ADDR_W-1:0] addr_q, cur_addr;
    logic [MEM_DATA_W-1:0] wdata_q, rdata_q, wdata_sh, rdata_ext;
    logic                  fault_q, fault, is_req, is_store;
    logic [3:0]            wmask;

    // the fault check looks at the incoming op while idle; everything else uses latched fields
    assign cur_op   = state_q == S_IDLE ? in_op : op_q;
    assign cur_addr = state_q == S_IDLE ? in_addr : addr_q;

    ysyx_23060332_lsu_align u_align (
        .op        (cur_op),
        .addr      (cur_addr),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .fault     (fault),
        .wmask     (wmask),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state: faults skip memory and go straight to the result
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (in_valid) state_d = fault ? S_DONE : S_REQ;
            S_REQ:  if (mem_req_ready) state_d = S_RSP;
            S_RSP:  if (mem_rsp_valid) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // latch the transaction on accept and capture load data on the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else if (state_q == S_IDLE && in_valid) begin
            op_q    <= in_op;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            rdata_q <= '0;
            fault_q <= fault;
        end else if (state_q == S_RSP && mem_rsp_valid && !op_q[OP_STORE]) begin
            rdata_q <= rdata_ext;
        end
    end

    assign is_req        = state_q == S_REQ;
    assign is_store      = op_q[OP_STORE];
    assign in_ready      = state_q == S_IDLE;
    assign mem_req_valid = is_req;
    assign mem_wen       = is_req && is_store;
    assign mem_addr      = is_req ? {addr_q[MEM_ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata     = is_req && is_store ? wdata_sh : '0;
    assign mem_wmask     = is_req && is_store ? {4'b0000, wmask} : 8'h00;
    assign mem_rsp_ready = state_q == S_RSP;
    assign out_valid     = state_q == S_DONE;
    assign out_rdata     = state_q == S_DONE ? rdata_q : '0;
    assign out_fault     = state_q == S_DONE && fault_q;
endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// tb_ysyx_23060332_lsu: directed checks of the LSU handshakes, lane handling and faults
module tb_ysyx_23060332_lsu;
    import ysyx_23060332_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [3:0]  in_op = '0;
    logic [31:0] in_addr = '0, in_wdata = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0, mem_rsp_ready;
    logic [31:0] mem_rdata = '0;
    logic        out_valid, out_ready = 1'b0, out_fault;
    logic [31:0] out_rdata;
    int          n_pass = 0, n_total = 0, hs_cnt = 0, hs_base;

    ysyx_23060332_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_req_valid && mem_req_ready) hs_cnt <= hs_cnt + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic accept(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        in_op = op;
        in_addr = addr;
        in_wdata = wdata;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_req_valid"}, mem_req_valid, 0);
        check({tag, "_wen"}, mem_wen, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_wmask"}, mem_wmask, 0);
        check({tag, "_rsp_ready"}, mem_rsp_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_rdata"}, out_rdata, 0);
        check({tag, "_out_fault"}, out_fault, 0);
    endtask

    initial begin
        #2;
        check_idle_outputs("rst");
        step();
        rst_n = 1'b1;
        step();

        // LW best case, everything tied high
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; out_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        accept(OP_LW, 32'h80000004, 32'h0);
        check("lw_c1_req_valid", mem_req_valid, 1);
        check("lw_c1_addr", mem_addr, 32'h80000004);
        check("lw_c1_wmask", mem_wmask, 0);
        check("lw_c1_wen", mem_wen, 0);
        check("lw_c1_out_valid", out_valid, 0);
        step();
        check("lw_c2_rsp_ready", mem_rsp_ready, 1);
        check("lw_c2_out_valid", out_valid, 0);
        step();
        check("lw_c3_out_valid", out_valid, 1);
        check("lw_c3_rdata", out_rdata, 32'hDEADBEEF);
        check("lw_c3_fault", out_fault, 0);
        step();
        check("lw_c4_in_ready", in_ready, 1);
        check("lw_c4_out_valid", out_valid, 0);

        // LB / LBU on the top byte
        mem_rdata = 32'h80123456;
        accept(OP_LB, 32'h80000003, 32'h0);
        check("lb_addr", mem_addr, 32'h80000000);
        step(); step();
        check("lb_rdata", out_rdata, 32'hFFFFFF80);
        step();
        accept(OP_LBU, 32'h80000003, 32'h0);
        step(); step();
        check("lbu_rdata", out_rdata, 32'h00000080);
        step();

        // LH / LHU on the upper half
        mem_rdata = 32'h80017777;
        accept(OP_LH, 32'h80000002, 32'h0);
        step(); step();
        check("lh_rdata", out_rdata, 32'hFFFF8001);
        step();
        accept(OP_LHU, 32'h80000002, 32'h0);
        step(); step();
        check("lhu_rdata", out_rdata, 32'h00008001);
        step();

        // SH: lane shift and mask, read data ignored
        mem_rdata = 32'hFFFFFFFF;
        accept(OP_SH, 32'h80000002, 32'h0000ABCD);
        check("sh_wen", mem_wen, 1);
        check("sh_addr", mem_addr, 32'h80000000);
        check("sh_wmask", mem_wmask, 8'h0C);
        check("sh_wdata", mem_wdata, 32'hABCD0000);
        step(); step();
        check("sh_out_valid", out_valid, 1);
        check("sh_out_rdata", out_rdata, 0);
        step();

        // SB at byte 1
        accept(OP_SB, 32'h80000001, 32'h0000005A);
        check("sb_wmask", mem_wmask, 8'h02);
        check("sb_wdata", mem_wdata, 32'h00005A00);
        step(); step(); step();

        // misaligned SW: fault next cycle, no request
        hs_base = hs_cnt;
        accept(OP_SW, 32'h80000001, 32'h12345678);
        check("sw_mis_out_valid", out_valid, 1);
        check("sw_mis_fault", out_fault, 1);
        check("sw_mis_req_valid", mem_req_valid, 0);
        check("sw_mis_rdata", out_rdata, 0);
        step();
        check("sw_mis_in_ready", in_ready, 1);
        check("sw_mis_no_hs", hs_cnt - hs_base, 0);

        // misaligned LH and reserved store encoding
        accept(OP_LH, 32'h80000003, 32'h0);
        check("lh_mis_fault", out_fault, 1);
        step();
        accept(4'b1100, 32'h80000000, 32'h0);
        check("rsvd_fault", out_fault, 1);
        check("rsvd_req_valid", mem_req_valid, 0);
        step();

        // backpressure on every channel
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; out_ready = 1'b0; mem_rdata = 32'h0000A500;
        hs_base = hs_cnt;
        accept(OP_LBU, 32'h80000001, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("bp_req_valid", mem_req_valid, 1);
            check("bp_req_addr", mem_addr, 32'h80000000);
            check("bp_req_wen", mem_wen, 0);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
        end
        check("bp_req_still_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("bp_rsp_ready", mem_rsp_ready, 1);
            check("bp_rsp_out_valid", out_valid, 0);
            step();
        end
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata = 32'h11111111;
        for (int i = 0; i < 2; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_rdata", out_rdata, 32'h000000A5);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_in_ready", in_ready, 1);
        check("bp_one_hs", hs_cnt - hs_base, 1);

        // reset while waiting for the response
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        accept(OP_LW, 32'h80000010, 32'h0);
        step();
        check("rst_mid_rsp_ready", mem_rsp_ready, 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        rst_n = 1'b1;
        step();
        check("rst_late_rsp_out_valid", out_valid, 0);
        check("rst_late_rsp_in_ready", in_ready, 1);
        mem_rdata = 32'h01020304;
        accept(OP_LW, 32'h80000004, 32'h0);
        check("rst_next_addr", mem_addr, 32'h80000004);
        step(); step();
        check("rst_next_out_valid", out_valid, 1);
        check("rst_next_rdata", out_rdata, 32'h01020304);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
